// File: rtl/core_pkg.sv
// Shared RV32 encoding constants: opcodes, field bit positions and the
// 12-bit immediate range used by both the packer and the core's sign-extender.
package core_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  localparam int IMM_MIN = -2048;
  localparam int IMM_MAX = 2047;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2,
    S_FULL  = 2'd3
  } pk_state_e;

  function automatic logic imm_fits12(input logic [31:0] imm);
    return ($signed(imm) >= IMM_MIN) && ($signed(imm) <= IMM_MAX);
  endfunction

endpackage

// File: rtl/instr_packer_if.sv
// Request and instruction-memory write bus of the instruction packer.
interface instr_packer_if #(
  parameter int ADDR_W = 8
);
  logic              start_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [6:0]        op_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [2:0]        funct3_i;
  logic [6:0]        funct7_i;
  logic [31:0]       imm_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic [ADDR_W:0]   count_o;
  logic              err_o;
  logic              full_o;

  modport master (
    output start_i, in_valid_i, op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    input  in_ready_o, mem_we_o, mem_addr_o, mem_data_o, count_o, err_o, full_o
  );

  modport slave (
    input  start_i, in_valid_i, op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
    output in_ready_o, mem_we_o, mem_addr_o, mem_data_o, count_o, err_o, full_o
  );
endinterface

// File: rtl/instr_encode.sv
// Combinational RV32 encoder: instruction fields + immediate -> word and legality.
// B-type immediates are halfword offsets, matching the core's sign-extender.
module instr_encode
  import core_pkg::*;
(
  input  logic [6:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);

  logic [11:0] w_imm;
  logic        w_imm_ok;

  assign w_imm    = i_imm[11:0];
  assign w_imm_ok = imm_fits12(i_imm);

  always_comb begin
    o_word      = '0;
    o_legal     = 1'b0;
    o_word[6:0] = i_op;
    case (i_op)
      OP_R: begin
        o_word[RD_LSB  +: 5] = i_rd;
        o_word[F3_LSB  +: 3] = i_funct3;
        o_word[RS1_LSB +: 5] = i_rs1;
        o_word[RS2_LSB +: 5] = i_rs2;
        o_word[F7_LSB  +: 7] = i_funct7;
        o_legal              = 1'b1;
      end
      OP_IALU, OP_LD: begin
        o_word[RD_LSB  +: 5] = i_rd;
        o_word[F3_LSB  +: 3] = i_funct3;
        o_word[RS1_LSB +: 5] = i_rs1;
        o_word[31:20]        = w_imm;
        o_legal              = w_imm_ok;
      end
      OP_SD: begin
        o_word[11:7]         = w_imm[4:0];
        o_word[F3_LSB  +: 3] = i_funct3;
        o_word[RS1_LSB +: 5] = i_rs1;
        o_word[RS2_LSB +: 5] = i_rs2;
        o_word[31:25]        = w_imm[11:5];
        o_legal              = w_imm_ok;
      end
      OP_BEQ: begin
        // imm[10] takes the slot that holds offset bit 11 in byte-offset form
        o_word[7]            = w_imm[10];
        o_word[11:8]         = w_imm[3:0];
        o_word[F3_LSB  +: 3] = i_funct3;
        o_word[RS1_LSB +: 5] = i_rs1;
        o_word[RS2_LSB +: 5] = i_rs2;
        o_word[30:25]        = w_imm[9:4];
        o_word[31]           = w_imm[11];
        o_legal              = w_imm_ok;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_packer.sv
// Instruction-memory loader: accepts decoded instructions, encodes them and
// writes them to sequential word addresses until DEPTH words are stored.
//
// state   | meaning
// IDLE    | waiting for start_i, not accepting
// RUN     | ready for one instruction description
// WRITE   | strobing mem_we_o with the encoded word at ptr
// FULL    | DEPTH words written, waiting for start_i
module instr_packer
  import core_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic          clk_i,
  input  logic          rst_i,
  instr_packer_if.slave bus
);

  pk_state_e         r_state;
  pk_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_count_inc;
  logic              r_err;
  logic [31:0]       r_data;
  logic [31:0]       w_word;
  logic              w_legal;
  logic              w_accept;

  instr_encode u_encode (
    .i_op     (bus.op_i),
    .i_rd     (bus.rd_i),
    .i_rs1    (bus.rs1_i),
    .i_rs2    (bus.rs2_i),
    .i_funct3 (bus.funct3_i),
    .i_funct7 (bus.funct7_i),
    .i_imm    (bus.imm_i),
    .o_word   (w_word),
    .o_legal  (w_legal)
  );

  // start_i outranks a same-cycle request
  assign w_accept    = (r_state == S_RUN) && bus.in_valid_i && !bus.start_i;
  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.start_i) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (w_accept && w_legal) w_state_nxt = S_WRITE;
        S_WRITE: w_state_nxt = (w_count_inc == (ADDR_W+1)'(DEPTH)) ? S_FULL : S_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else if (bus.start_i) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept && w_legal)  r_data <= w_word;
      if (w_accept && !w_legal) r_err  <= 1'b1;
      if (r_state == S_WRITE) begin
        r_ptr   <= r_ptr + 1'b1;
        r_count <= w_count_inc;
      end
    end
  end

  // Strobe and ready decode straight from the state register so reset drops them at once
  assign bus.in_ready_o = (r_state == S_RUN);
  assign bus.mem_we_o   = (r_state == S_WRITE);
  assign bus.full_o     = (r_state == S_FULL);
  assign bus.mem_addr_o = r_ptr;
  assign bus.mem_data_o = r_data;
  assign bus.count_o    = r_count;
  assign bus.err_o      = r_err;

endmodule

// File: tb/tb_instr_packer.sv
// Scoreboard bench for instr_packer (DEPTH=4): expected writes are queued when
// a legal request is driven and checked when mem_we_o is observed.
module tb_instr_packer;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  logic [7:0]  exp_ptr = '0;
  logic [31:0] last_wr_data = '0;

  instr_packer_if #(.ADDR_W(8)) bus ();

  instr_packer #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every observed write must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.mem_we_o === 1'b1) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%h, no write expected", bus.mem_addr_o, bus.mem_data_o);
      end else begin
        e = sb_q.pop_front();
        last_wr_data = bus.mem_data_o;
        if (bus.mem_addr_o !== e.addr || bus.mem_data_o !== e.data) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   bus.mem_addr_o, bus.mem_data_o, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] sext_b(input logic [31:0] w);
    logic [11:0] h;
    h = {w[31], w[7], w[30:25], w[11:8]};
    return {{20{h[11]}}, h};
  endfunction

  function automatic logic [31:0] ref_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input bit push, input logic [31:0] exp_data);
    int n = 0;
    while (bus.in_ready_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (bus.in_ready_o !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_ready: in_ready_o=%b, required 1 within 20 cycles", bus.in_ready_o);
      return;
    end
    bus.op_i = op; bus.rd_i = rd; bus.rs1_i = rs1; bus.rs2_i = rs2;
    bus.funct3_i = f3; bus.funct7_i = f7; bus.imm_i = imm;
    bus.in_valid_i = 1'b1;
    if (push) begin
      sb_q.push_back('{exp_ptr, exp_data});
      exp_ptr++;
    end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic do_start();
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    exp_ptr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({bus.in_ready_o, bus.mem_we_o, bus.err_o, bus.full_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: ready/we/err/full=%b, expected 0000",
               {bus.in_ready_o, bus.mem_we_o, bus.err_o, bus.full_o});
    end
    checks++;
    if (bus.count_o !== 9'd0 || bus.mem_addr_o !== 8'd0 || bus.mem_data_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: count=%0d addr=%0d data=%h, expected 0 0 0",
               bus.count_o, bus.mem_addr_o, bus.mem_data_o);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: in_ready_o=%b, expected 0", bus.in_ready_o);
    end
  endtask

  task automatic test_r_type();
    do_start();
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL run_ready: in_ready_o=%b, expected 1", bus.in_ready_o);
    end
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3);
    @(posedge clk); #1;
    checks++;
    if (bus.count_o !== 9'd1) begin
      errors++;
      $display("FAIL r_count: count_o=%0d, expected 1", bus.count_o);
    end
  endtask

  task automatic test_i_sd();
    do_start();
    send(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF00293);
    send(7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE512E23);
    @(posedge clk); #1;
    checks++;
    if (bus.count_o !== 9'd2) begin
      errors++;
      $display("FAIL i_sd_count: count_o=%0d, expected 2", bus.count_o);
    end
  endtask

  task automatic test_beq();
    do_start();
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE208CE3);
    @(posedge clk); #1;
    checks++;
    if (sext_b(last_wr_data) !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL beq_roundtrip: decoded=%h, expected FFFFFFFC", sext_b(last_wr_data));
    end
  endtask

  task automatic test_illegal();
    do_start();
    send(7'b0110011, 5'd7, 5'd4, 5'd6, 3'd0, 7'd0, 32'd0, 1'b1, ref_r(5'd7, 5'd4, 5'd6));
    @(posedge clk); #1;
    send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0);
    checks++;
    if (bus.err_o !== 1'b1 || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL illegal_imm: err=%b ready=%b, expected err=1 ready=1", bus.err_o, bus.in_ready_o);
    end
    send(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
    checks++;
    if (bus.count_o !== 9'd1) begin
      errors++;
      $display("FAIL illegal_count: count_o=%0d, expected 1", bus.count_o);
    end
    send(7'b0110011, 5'd8, 5'd9, 5'd10, 3'd0, 7'd0, 32'd0, 1'b1, ref_r(5'd8, 5'd9, 5'd10));
    @(posedge clk); #1;
    checks++;
    if (bus.count_o !== 9'd2 || bus.err_o !== 1'b1) begin
      errors++;
      $display("FAIL illegal_after: count=%0d err=%b, expected 2 and 1", bus.count_o, bus.err_o);
    end
    do_start();
    checks++;
    if (bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err_o=%b, expected 0", bus.err_o);
    end
  endtask

  task automatic test_start_priority();
    do_start();
    bus.op_i = 7'b0110011; bus.rd_i = 5'd1; bus.rs1_i = 5'd1; bus.rs2_i = 5'd1;
    bus.funct3_i = 3'd0; bus.funct7_i = 7'd0; bus.imm_i = 32'd0;
    bus.in_valid_i = 1'b1; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0; bus.start_i = 1'b0;
    checks++;
    if (bus.in_ready_o !== 1'b1 || bus.count_o !== 9'd0) begin
      errors++;
      $display("FAIL start_priority: ready=%b count=%0d, expected 1 and 0", bus.in_ready_o, bus.count_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(7'b0110011, 5'(i + 1), 5'(i + 11), 5'(i + 21), 3'd0, 7'd0, 32'd0, 1'b1,
           ref_r(5'(i + 1), 5'(i + 11), 5'(i + 21)));
    end
    @(posedge clk); #1;
    checks++;
    if (bus.full_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.count_o !== 9'd4) begin
      errors++;
      $display("FAIL full: full=%b ready=%b count=%0d, expected 1 0 4",
               bus.full_o, bus.in_ready_o, bus.count_o);
    end
    bus.op_i = 7'b0110011; bus.rd_i = 5'd30; bus.in_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1; bus.in_valid_i = 1'b0;
    checks++;
    if (bus.count_o !== 9'd4 || bus.full_o !== 1'b1) begin
      errors++;
      $display("FAIL full_hold: count=%0d full=%b, expected 4 and 1", bus.count_o, bus.full_o);
    end
    do_start();
    checks++;
    if (bus.count_o !== 9'd0 || bus.full_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL full_restart: count=%0d full=%b ready=%b, expected 0 0 1",
               bus.count_o, bus.full_o, bus.in_ready_o);
    end
    send(7'b0110011, 5'd31, 5'd30, 5'd29, 3'd0, 7'd0, 32'd0, 1'b1, ref_r(5'd31, 5'd30, 5'd29));
    @(posedge clk); #1;
  endtask

  task automatic test_mid_write();
    do_start();
    // start inside WRITE: strobe visible this cycle, then discarded
    send(7'b0110011, 5'd2, 5'd3, 5'd4, 3'd0, 7'd0, 32'd0, 1'b1, ref_r(5'd2, 5'd3, 5'd4));
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    exp_ptr = '0;
    checks++;
    if (bus.mem_we_o !== 1'b0 || bus.count_o !== 9'd0) begin
      errors++;
      $display("FAIL start_mid_write: we=%b count=%0d, expected 0 and 0", bus.mem_we_o, bus.count_o);
    end
    // reset inside WRITE: strobe drops without a clock edge
    send(7'b0110011, 5'd5, 5'd6, 5'd7, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_we_o !== 1'b0 || bus.count_o !== 9'd0) begin
      errors++;
      $display("FAIL rst_mid_write: we=%b count=%0d, expected 0 and 0", bus.mem_we_o, bus.count_o);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.start_i = 1'b0; bus.in_valid_i = 1'b0;
    bus.op_i = '0; bus.rd_i = '0; bus.rs1_i = '0; bus.rs2_i = '0;
    bus.funct3_i = '0; bus.funct7_i = '0; bus.imm_i = '0;
    test_reset();
    test_r_type();
    test_i_sd();
    test_beq();
    test_illegal();
    test_start_priority();
    test_back_to_back();
    test_mid_write();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected writes never seen, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
